// File: rtl/echo_pkg.sv
// echo_pkg: shared types and constants for the echo mixer.
//   DEF_DATA_WIDTH / DEF_GAIN_WIDTH : default sample and gain widths
//   sample_t                        : signed audio sample
//   state_t                         : mixer FSM states
//   SAT_MAX / SAT_MIN               : saturation bounds of a sample
package echo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_GAIN_WIDTH = 8;

   typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      MIX,
      OUT
   } state_t;

   localparam sample_t SAT_MAX = 16'h7FFF;
   localparam sample_t SAT_MIN = 16'h8000;

endpackage

// File: rtl/echo_delay_line.sv
// echo_delay_line: 2^DELAY_AW x DATA_WIDTH circular sample store.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_we         : write i_wdata at the write pointer and advance it
//   i_wdata      : sample to store
//   i_rd_addr    : combinational read address
//   o_rd_data    : sample at i_rd_addr
//   o_wptr       : current write pointer
//   o_filled     : set once the pointer has wrapped; sticky until reset
// The storage array itself is not reset.
module echo_delay_line #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DELAY_AW   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DELAY_AW-1:0]   i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [DELAY_AW-1:0]   o_wptr,
   output logic                  o_filled
);

   localparam int unsigned DEPTH = 1 << DELAY_AW;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DELAY_AW-1:0]   r_wptr;
   logic                  r_filled;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr   <= '0;
         r_filled <= 1'b0;
      end else if (i_we) begin
         r_wptr <= r_wptr + 1'b1;
         // Wrapping from the last slot means every slot now holds a real sample
         if (r_wptr == {DELAY_AW{1'b1}}) begin
            r_filled <= 1'b1;
         end
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];
   assign o_wptr    = r_wptr;
   assign o_filled  = r_filled;

endmodule

// File: rtl/echo_mixer.sv
// echo_mixer: pops samples from the upstream FIFO and mixes each with a
// gain-scaled copy of the sample 2^DELAY_AW samples earlier, saturating the sum.
//   clk, rst      : clock, asynchronous active-high reset
//   fifo_rd_data  : FIFO data, valid the cycle after a pop
//   fifo_rd_en    : pop request (combinational, IDLE only)
//   fifo_empty    : FIFO empty flag
//   gain          : unsigned Q0.GAIN_WIDTH echo gain, sampled in MIX
//   bypass        : pass the dry sample through, sampled in MIX
//   out_data      : mixed sample, held until accepted
//   out_valid     : out_data valid
//   out_ready     : downstream accept
//   sat_pulse     : one-cycle flag, alongside the first cycle of a clamped output
// Build option: define ECHO_FEEDBACK_EN to store the wet mix result in the
// delay line (recirculating echo); otherwise the dry sample is stored.
module echo_mixer
   import echo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DELAY_AW   = 4,
   parameter int unsigned GAIN_WIDTH = DEF_GAIN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   input  logic                  fifo_empty,
   input  logic [GAIN_WIDTH-1:0] gain,
   input  logic                  bypass,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sat_pulse
);

   localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam logic signed [PW-1:0] LIM_MAX = PW'(SAT_MAX);
   localparam logic signed [PW-1:0] LIM_MIN = PW'(SAT_MIN);

   state_t r_state;
   state_t w_state_next;

   logic signed [DATA_WIDTH-1:0] r_x;
   logic signed [DATA_WIDTH-1:0] r_d;
   logic [DATA_WIDTH-1:0]        r_out_data;
   logic                         r_out_valid;
   logic                         r_sat;

   logic [DELAY_AW-1:0]   w_wptr;
   logic                  w_filled;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_we;

   logic signed [PW-1:0]  w_p;
   logic signed [PW-1:0]  w_e;
   logic signed [PW-1:0]  w_s;
   logic                  w_hi;
   logic                  w_lo;
   logic [DATA_WIDTH-1:0] w_y;

   // Gated by rst so no pop is requested while held in reset
   assign fifo_rd_en = (r_state == IDLE) && !fifo_empty && !rst;
   assign w_we       = (r_state == MIX);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (fifo_rd_en) w_state_next = CAPTURE;
         CAPTURE: w_state_next = MIX;
         MIX:     w_state_next = OUT;
         OUT:     if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Echo term: delayed sample times gain, floored back to sample scale.
   // The full product width keeps the sum exact, so clamping is a plain compare.
   always_comb begin
      w_p  = $signed({{(GAIN_WIDTH+1){r_d[DATA_WIDTH-1]}}, r_d})
           * $signed({{(DATA_WIDTH+1){1'b0}}, gain});
      w_e  = w_p >>> GAIN_WIDTH;
      w_s  = $signed({{(GAIN_WIDTH+1){r_x[DATA_WIDTH-1]}}, r_x}) + w_e;
      w_hi = (w_s > LIM_MAX);
      w_lo = (w_s < LIM_MIN);
      w_y  = w_s[DATA_WIDTH-1:0];
      if (w_hi) begin
         w_y = SAT_MAX;
      end else if (w_lo) begin
         w_y = SAT_MIN;
      end
   end

`ifdef ECHO_FEEDBACK_EN
   assign w_wdata = w_y;
`else
   assign w_wdata = r_x;
`endif

   echo_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DELAY_AW   (DELAY_AW)
   ) u_delay (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_we      (w_we),
      .i_wdata   (w_wdata),
      .i_rd_addr (w_wptr),
      .o_rd_data (w_rd_data),
      .o_wptr    (w_wptr),
      .o_filled  (w_filled)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_d         <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_sat   <= 1'b0;
         case (r_state)
            CAPTURE: begin
               r_x <= fifo_rd_data;
               // Slots not yet written since reset contribute silence
               r_d <= w_filled ? w_rd_data : '0;
            end
            MIX: begin
               r_out_data  <= bypass ? r_x : w_y;
               r_sat       <= !bypass && (w_hi || w_lo);
               r_out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign sat_pulse = r_sat;

endmodule

// File: tb/tb_echo_mixer.sv
// tb_echo_mixer: self-checking bench for echo_mixer. A behavioural FIFO feeds
// samples; expected outputs come from a sample-history model and a vector table.
module tb_echo_mixer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] fifo_rd_data;
   logic        fifo_rd_en;
   logic        fifo_empty;
   logic [7:0]  gain = 8'h00;
   logic        bypass = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        sat_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   echo_mixer dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_empty   (fifo_empty),
      .gain         (gain),
      .bypass       (bypass),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sat_pulse    (sat_pulse)
   );

   always #5 clk = ~clk;

   // FIFO model: source array written by the stimulus, popped here
   logic [15:0] src [0:1023];
   int n_pushed  = 0;
   int n_popped  = 0;
   int rd_en_cnt = 0;

   assign fifo_empty = (n_popped >= n_pushed);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= src[n_popped];
         n_popped     <= n_popped + 1;
         rd_en_cnt    <= rd_en_cnt + 1;
      end
   end

   // Reference model: history of stored samples, indexed by output number
   int          hist [0:1023];
   int          m_n = 0;
   logic [16:0] exp_q [$];

   typedef struct {
      bit          rst_before;
      logic [15:0] x;
      logic [7:0]  g;
      bit          byp;
      bit          chk;
      logic [15:0] exp_out;
      bit          exp_sat;
   } vec_t;

   vec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic [15:0] xv, input logic [7:0] g, input bit byp,
                             output logic [15:0] yo, output bit so);
      int x, d, e, s, y;
      bit cl;
      x  = int'($signed(xv));
      d  = (m_n >= DEPTH) ? hist[m_n-DEPTH] : 0;
      e  = (d * int'(g)) >>> 8;
      s  = x + e;
      y  = s;
      cl = 1'b0;
      if (s > 32767) begin
         y  = 32767;
         cl = 1'b1;
      end else if (s < -32768) begin
         y  = -32768;
         cl = 1'b1;
      end
`ifdef ECHO_FEEDBACK_EN
      hist[m_n] = y;
`else
      hist[m_n] = x;
`endif
      m_n++;
      yo = byp ? xv : y[15:0];
      so = !byp && cl;
   endtask

   task automatic push_sample(input logic [15:0] xv);
      logic [15:0] yo;
      bit          so;
      model_step(xv, gain, bypass, yo, so);
      exp_q.push_back({so, yo});
      src[n_pushed] = xv;
      n_pushed++;
   endtask

   // Waits (bounded) for out_valid, then compares against the model queue
   task automatic wait_output(input string name);
      logic [16:0] ex;
      bit          got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = out_valid;
      end
      check({name, "_valid"}, 32'(got), 32'd1);
      ex = exp_q.pop_front();
      if (got) begin
         check({name, "_data"}, 32'(out_data), 32'(ex[15:0]));
         check({name, "_sat"}, 32'(sat_pulse), 32'(ex[16]));
      end
   endtask

   task automatic do_sample(input logic [15:0] x, input logic [7:0] g, input bit byp,
                            input bit chk, input logic [15:0] eo, input bit es,
                            input string name);
      int c0;
      gain   = g;
      bypass = byp;
      c0     = rd_en_cnt;
      push_sample(x);
      wait_output(name);
      if (chk) begin
         check({name, "_tbl_data"}, 32'(out_data), 32'(eo));
         check({name, "_tbl_sat"}, 32'(sat_pulse), 32'(es));
      end
      @(negedge clk);
      check({name, "_released"}, 32'(out_valid), 32'd0);
      check({name, "_sat_once"}, 32'(sat_pulse), 32'd0);
      check({name, "_one_pop"}, 32'(rd_en_cnt - c0), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_n = 0;
      exp_q.delete();
   endtask

   task automatic add_vec(input bit r, input logic [15:0] x, input logic [7:0] g, input bit b,
                          input bit c, input logic [15:0] eo, input bit es);
      vec_t v;
      v.rst_before = r;
      v.x          = x;
      v.g          = g;
      v.byp        = b;
      v.chk        = c;
      v.exp_out    = eo;
      v.exp_sat    = es;
      tbl.push_back(v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] xr;
      logic [15:0] bp_exp;
      logic [15:0] echo33;

`ifdef ECHO_FEEDBACK_EN
      echo33 = 16'h0400;
`else
      echo33 = 16'h0000;
`endif

      // Fill-phase passthrough
      add_vec(1, 16'h1234, 8'h80, 0, 1, 16'h1234, 0);
      add_vec(0, 16'h0000, 8'h80, 0, 1, 16'h0000, 0);
      add_vec(0, 16'h0001, 8'h80, 0, 1, 16'h0001, 0);
      // Echo tap: impulse then silence, outputs #17 and #33
      add_vec(1, 16'h1000, 8'h80, 0, 1, 16'h1000, 0);
      for (int k = 2; k <= 33; k++) begin
         if (k == 17)      add_vec(0, 16'h0000, 8'h80, 0, 1, 16'h0800, 0);
         else if (k == 33) add_vec(0, 16'h0000, 8'h80, 0, 1, echo33, 0);
         else              add_vec(0, 16'h0000, 8'h80, 0, 0, 16'h0000, 0);
      end
      // Positive and negative saturation
      for (int k = 1; k <= 17; k++) begin
         add_vec(k == 1, 16'h7000, 8'hFF, 0, 1, (k == 17) ? 16'h7FFF : 16'h7000, k == 17);
      end
      for (int k = 1; k <= 17; k++) begin
         add_vec(k == 1, 16'h9000, 8'hFF, 0, 1, (k == 17) ? 16'h8000 : 16'h9000, k == 17);
      end
      // Bypass after the line is full of 0x1000
      for (int k = 1; k <= 16; k++) begin
         add_vec(k == 1, 16'h1000, 8'h80, 0, 1, 16'h1000, 0);
      end
      add_vec(0, 16'h0100, 8'h80, 1, 1, 16'h0100, 0);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_sat_pulse", 32'(sat_pulse), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_empty_no_pop", 32'(fifo_rd_en), 32'd0);

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) do_reset();
         do_sample(tbl[i].x, tbl[i].g, tbl[i].byp, tbl[i].chk, tbl[i].exp_out,
                   tbl[i].exp_sat, $sformatf("vec%0d", i));
      end

      // Randomised run against the model
      do_reset();
      for (int i = 0; i < 60; i++) begin
         xr = 16'($urandom);
         do_sample(xr, 8'($urandom), $urandom_range(0, 7) == 0, 0, 16'h0, 0,
                   $sformatf("rnd%0d", i));
      end

      // Backpressure with a second sample waiting in the FIFO
      gain      = 8'h40;
      bypass    = 1'b0;
      out_ready = 1'b0;
      push_sample(16'h0321);
      push_sample(16'h7ABC);
      bp_exp = exp_q[0][15:0];
      wait_output("bp_first");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_data", 32'(out_data), 32'(bp_exp));
         check("bp_no_pop", 32'(fifo_rd_en), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_pop_resume", 32'(fifo_rd_en), 32'd1);
      wait_output("bp_second");
      @(negedge clk);
      check("bp_second_released", 32'(out_valid), 32'd0);

      // Reset while in MIX: the popped sample is dropped, history forgotten
      do_sample(16'h0123, 8'h00, 1, 1, 16'h0123, 0, "pre_rst");
      src[n_pushed] = 16'h4321;
      n_pushed++;
      #1;
      check("mixrst_pop_req", 32'(fifo_rd_en), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mixrst_out_data", 32'(out_data), 32'd0);
      check("mixrst_out_valid", 32'(out_valid), 32'd0);
      check("mixrst_sat", 32'(sat_pulse), 32'd0);
      check("mixrst_rd_en", 32'(fifo_rd_en), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_n = 0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         xr = 16'($urandom);
         do_sample(xr, 8'h80, 0, 1, xr, 0, $sformatf("postrst%0d", i));
      end
      xr = 16'($urandom);
      do_sample(xr, 8'h80, 0, 0, 16'h0, 0, "postrst_echo");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
